// File: rtl/imm_ext_arbiter_pkg.sv
// Shared constants for the immediate-extension arbiter: extension mode encodings
// and default datapath widths.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SIGN  = 2'b00;
    localparam logic [1:0] MODE_ZERO  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_BYTE  = 2'b11;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Request/result bundle between the two requesters, the consumer and the arbiter.
// slave = arbiter side, master = requesters plus consumer side.
interface imm_ext_arbiter_if #(
    parameter int IN_W  = imm_ext_pkg::IN_W,
    parameter int OUT_W = imm_ext_pkg::OUT_W
);
    logic             req0_valid;
    logic             req0_ready;
    logic [IN_W-1:0]  req0_imm;
    logic [1:0]       req0_mode;
    logic             req1_valid;
    logic             req1_ready;
    logic [IN_W-1:0]  req1_imm;
    logic [1:0]       req1_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_src;

    modport slave (
        input  req0_valid, req0_imm, req0_mode,
        input  req1_valid, req1_imm, req1_mode,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_src
    );

    modport master (
        output req0_valid, req0_imm, req0_mode,
        output req1_valid, req1_imm, req1_mode,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_src
    );
endinterface

// File: rtl/imm_ext_arbiter_unit.sv
// Combinational immediate extender: all width and mode handling lives here.
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = imm_ext_pkg::IN_W,
    parameter int OUT_W = imm_ext_pkg::OUT_W
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);

    always_comb begin
        ext = '0;
        case (mode)
            MODE_SIGN:  ext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
            MODE_ZERO:  ext = {{(OUT_W-IN_W){1'b0}}, imm};
            MODE_UPPER: ext = {imm, {(OUT_W-IN_W){1'b0}}};
            // Only the low byte matters; the upper immediate bits are don't-care.
            MODE_BYTE:  ext = {{(OUT_W-8){imm[7]}}, imm[7:0]};
            default:    ext = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender between decode (req0) and
// the branch-target unit (req1), with a 1-deep registered result slot.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = imm_ext_pkg::IN_W,
    parameter int OUT_W = imm_ext_pkg::OUT_W
) (
    input  logic               clk,
    input  logic               reset,
    imm_ext_arbiter_if.slave   bus
);

    logic             out_valid_reg;
    logic             out_src_reg;
    logic             last_grant_reg;
    logic [OUT_W-1:0] out_data_reg;

    logic             can_accept;
    logic             grant_any;
    logic             grant_idx;
    logic             accept;
    logic [IN_W-1:0]  sel_imm;
    logic [1:0]       sel_mode;
    logic [OUT_W-1:0] ext;

    always_comb begin
        can_accept = !out_valid_reg || bus.out_ready;
        grant_any  = bus.req0_valid || bus.req1_valid;
        // With a single requester its index is simply req1_valid; a tie goes to
        // whoever did not win last.
        if (bus.req0_valid && bus.req1_valid)
            grant_idx = !last_grant_reg;
        else
            grant_idx = bus.req1_valid;
        accept   = can_accept && grant_any;
        sel_imm  = grant_idx ? bus.req1_imm  : bus.req0_imm;
        sel_mode = grant_idx ? bus.req1_mode : bus.req0_mode;
    end

    imm_ext_unit #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext (
        .imm  (sel_imm),
        .mode (sel_mode),
        .ext  (ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_src_reg    <= 1'b0;
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            out_valid_reg  <= 1'b1;
            out_data_reg   <= ext;
            out_src_reg    <= grant_idx;
            last_grant_reg <= grant_idx;
        end else if (bus.out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign bus.req0_ready = accept && !grant_idx;
    assign bus.req1_ready = accept && grant_idx;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_data   = out_data_reg;
    assign bus.out_src    = out_src_reg;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed, table-driven bench for imm_ext_arbiter: readys checked before each
// edge, registered outputs checked just after it.
module tb_imm_ext_arbiter;
    import imm_ext_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    imm_ext_arbiter_if #(.IN_W(16), .OUT_W(32)) bus ();

    imm_ext_arbiter #(.IN_W(16), .OUT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [15:0] i0;
        logic [1:0]  m0;
        logic        v1;
        logic [15:0] i1;
        logic [1:0]  m1;
        logic        ordy;
        logic        er0;
        logic        er1;
        logic        eov;
        logic [31:0] ed;
        logic        es;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v0, logic [15:0] i0, logic [1:0] m0,
                                logic v1, logic [15:0] i1, logic [1:0] m1,
                                logic ordy, logic er0, logic er1,
                                logic eov, logic [31:0] ed, logic es);
        vec_t v;
        v.v0 = v0; v.i0 = i0; v.m0 = m0;
        v.v1 = v1; v.i1 = i1; v.m1 = m1;
        v.ordy = ordy; v.er0 = er0; v.er1 = er1;
        v.eov = eov; v.ed = ed; v.es = es;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic v0, logic [15:0] i0, logic [1:0] m0,
                         logic v1, logic [15:0] i1, logic [1:0] m1, logic ordy);
        bus.req0_valid = v0; bus.req0_imm = i0; bus.req0_mode = m0;
        bus.req1_valid = v1; bus.req1_imm = i1; bus.req1_mode = m1;
        bus.out_ready  = ordy;
    endtask

    task automatic apply(int idx, vec_t v);
        drive(v.v0, v.i0, v.m0, v.v1, v.i1, v.m1, v.ordy);
        #1;
        chk($sformatf("v%0d req0_ready", idx), {31'b0, bus.req0_ready}, {31'b0, v.er0});
        chk($sformatf("v%0d req1_ready", idx), {31'b0, bus.req1_ready}, {31'b0, v.er1});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", idx), {31'b0, bus.out_valid}, {31'b0, v.eov});
        chk($sformatf("v%0d out_data", idx), bus.out_data, v.ed);
        chk($sformatf("v%0d out_src", idx), {31'b0, bus.out_src}, {31'b0, v.es});
        $display("vec %0d: v0=%b v1=%b ordy=%b -> rdy=%b%b ov=%b data=%h src=%b",
                 idx, v.v0, v.v1, v.ordy, v.er1, v.er0,
                 bus.out_valid, bus.out_data, bus.out_src);
    endtask

    initial begin
        // Single requester, round-robin alternation, extension modes.
        vecs.push_back(mk(1, 16'h8001, MODE_SIGN, 0, 16'h0000, MODE_SIGN, 1, 1, 0, 1, 32'hFFFF8001, 0));
        vecs.push_back(mk(1, 16'h0001, MODE_ZERO, 1, 16'h0002, MODE_ZERO, 1, 0, 1, 1, 32'h00000002, 1));
        vecs.push_back(mk(1, 16'h0001, MODE_ZERO, 1, 16'h0002, MODE_ZERO, 1, 1, 0, 1, 32'h00000001, 0));
        vecs.push_back(mk(1, 16'h0001, MODE_ZERO, 1, 16'h0002, MODE_ZERO, 1, 0, 1, 1, 32'h00000002, 1));
        vecs.push_back(mk(1, 16'h0001, MODE_ZERO, 1, 16'h0002, MODE_ZERO, 1, 1, 0, 1, 32'h00000001, 0));
        vecs.push_back(mk(0, 16'h0000, MODE_SIGN, 1, 16'h1234, MODE_UPPER, 1, 0, 1, 1, 32'h12340000, 1));
        vecs.push_back(mk(0, 16'h0000, MODE_SIGN, 1, 16'hAB80, MODE_BYTE, 1, 0, 1, 1, 32'hFFFFFF80, 1));
        vecs.push_back(mk(1, 16'hAB7F, MODE_BYTE, 0, 16'h0000, MODE_SIGN, 1, 1, 0, 1, 32'h0000007F, 0));
        vecs.push_back(mk(1, 16'hFFFF, MODE_ZERO, 0, 16'h0000, MODE_SIGN, 1, 1, 0, 1, 32'h0000FFFF, 0));
        vecs.push_back(mk(1, 16'h7FFF, MODE_SIGN, 0, 16'h0000, MODE_SIGN, 1, 1, 0, 1, 32'h00007FFF, 0));
        // Drain with no request: data/src hold, last_grant untouched.
        vecs.push_back(mk(0, 16'h0000, MODE_SIGN, 0, 16'h0000, MODE_SIGN, 1, 0, 0, 0, 32'h00007FFF, 0));
        vecs.push_back(mk(0, 16'h0000, MODE_SIGN, 0, 16'h0000, MODE_SIGN, 1, 0, 0, 0, 32'h00007FFF, 0));
        vecs.push_back(mk(1, 16'h0011, MODE_ZERO, 1, 16'h0022, MODE_ZERO, 1, 0, 1, 1, 32'h00000022, 1));
        vecs.push_back(mk(0, 16'h0000, MODE_SIGN, 0, 16'h0000, MODE_SIGN, 1, 0, 0, 0, 32'h00000022, 1));
        // Fill the empty slot with out_ready low, then hold backpressure.
        vecs.push_back(mk(1, 16'h0005, MODE_ZERO, 0, 16'h0000, MODE_SIGN, 0, 1, 0, 1, 32'h00000005, 0));
        vecs.push_back(mk(1, 16'h0011, MODE_ZERO, 1, 16'h0022, MODE_ZERO, 0, 0, 0, 1, 32'h00000005, 0));
        vecs.push_back(mk(1, 16'h0011, MODE_ZERO, 1, 16'h0022, MODE_ZERO, 0, 0, 0, 1, 32'h00000005, 0));
        vecs.push_back(mk(1, 16'h0011, MODE_ZERO, 1, 16'h0022, MODE_ZERO, 0, 0, 0, 1, 32'h00000005, 0));
        // Release: drain and accept on the same edge, no bubble.
        vecs.push_back(mk(1, 16'h0011, MODE_ZERO, 1, 16'h0022, MODE_ZERO, 1, 0, 1, 1, 32'h00000022, 1));
        vecs.push_back(mk(1, 16'h0011, MODE_ZERO, 1, 16'h0022, MODE_ZERO, 1, 1, 0, 1, 32'h00000011, 0));

        reset = 1'b1;
        drive(0, 16'h0, MODE_SIGN, 0, 16'h0, MODE_SIGN, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset out_data", bus.out_data, 32'd0);
        chk("reset out_src", {31'b0, bus.out_src}, 32'd0);

        for (int i = 0; i < vecs.size(); i++)
            apply(i, vecs[i]);

        // Reset while a result is held under backpressure; last_grant is 0 here,
        // so only a real reset of it lets req0 win the next tie.
        drive(1, 16'h0011, MODE_ZERO, 1, 16'h0022, MODE_ZERO, 0);
        reset = 1'b1;
        #1;
        chk("pre-reset req0_ready", {31'b0, bus.req0_ready}, 32'd0);
        chk("pre-reset req1_ready", {31'b0, bus.req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midreset out_data", bus.out_data, 32'd0);
        chk("midreset out_src", {31'b0, bus.out_src}, 32'd0);
        $display("reset mid-transfer: ov=%b data=%h", bus.out_valid, bus.out_data);

        drive(1, 16'h0011, MODE_ZERO, 1, 16'h0022, MODE_ZERO, 1);
        #1;
        chk("post-reset req0_ready", {31'b0, bus.req0_ready}, 32'd1);
        chk("post-reset req1_ready", {31'b0, bus.req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("post-reset out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("post-reset out_data", bus.out_data, 32'h00000011);
        chk("post-reset out_src", {31'b0, bus.out_src}, 32'd0);
        $display("post-reset tie: ov=%b data=%h src=%b", bus.out_valid, bus.out_data, bus.out_src);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
